// File: rtl/id_exe_pipe_pkg.sv
// Shared definitions for the ID/EXE pipeline register: ALU op codes,
// operand forwarding selects and the EXE-stage register layout.
package id_exe_pipe_pkg;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0100;
    localparam logic [3:0] ALU_AND = 4'b0001;
    localparam logic [3:0] ALU_OR  = 4'b0101;
    localparam logic [3:0] ALU_XOR = 4'b0010;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        FWD_REG  = 2'b00,
        FWD_EALU = 2'b01,
        FWD_MALU = 2'b10,
        FWD_MMEM = 2'b11
    } fwd_t;

    typedef struct packed {
        logic        wreg;
        logic        m2reg;
        logic        wmem;
        logic        aluimm;
        logic [3:0]  aluc;
        logic [4:0]  rn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic        valid;
    } exe_t;

    // A stage can supply a source register only if it writes a non-zero register that matches.
    function automatic logic reg_hit(input logic wr, input logic [4:0] rn, input logic [4:0] src);
        return wr && (rn != REG_ZERO) && (rn == src);
    endfunction

endpackage

// File: rtl/id_exe_pipe_fwd_sel.sv
// Forwarding select and operand mux for one ID-stage source register.
// EXE results take priority over MEM; loads in EXE are never forwarded.
module fwd_sel
    import id_exe_pipe_pkg::*;
(
    input  logic        ewreg,
    input  logic        em2reg,
    input  logic [4:0]  ern,
    input  logic        m_wreg,
    input  logic        m_m2reg,
    input  logic [4:0]  m_rn,
    input  logic [4:0]  src,
    input  logic [31:0] qreg,
    input  logic [31:0] e_alu,
    input  logic [31:0] m_alu,
    input  logic [31:0] m_mdata,
    output logic [31:0] opnd
);

    fwd_t fwd;

    always_comb begin
        fwd = FWD_REG;
        if (reg_hit(ewreg && !em2reg, ern, src)) begin
            fwd = FWD_EALU;
        end else if (reg_hit(m_wreg && !m_m2reg, m_rn, src)) begin
            fwd = FWD_MALU;
        end else if (reg_hit(m_wreg && m_m2reg, m_rn, src)) begin
            fwd = FWD_MMEM;
        end
    end

    always_comb begin
        opnd = qreg;
        case (fwd)
            FWD_EALU: opnd = e_alu;
            FWD_MALU: opnd = m_alu;
            FWD_MMEM: opnd = m_mdata;
            default:  opnd = qreg;
        endcase
    end

endmodule

// File: rtl/id_exe_pipe.sv
// ID/EXE pipeline register with operand forwarding and load-use stall.
// A stall or flush loads a bubble; the bubble clears em2reg so a stall lasts one cycle.
module id_exe_pipe
    import id_exe_pipe_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        d_wreg,
    input  logic        d_m2reg,
    input  logic        d_wmem,
    input  logic        d_aluimm,
    input  logic [3:0]  d_aluc,
    input  logic [4:0]  d_rs,
    input  logic [4:0]  d_rt,
    input  logic        d_uses_rt,
    input  logic [4:0]  d_rn,
    input  logic [31:0] d_qa,
    input  logic [31:0] d_qb,
    input  logic [31:0] d_imm,
    input  logic [31:0] e_alu,
    input  logic        m_wreg,
    input  logic        m_m2reg,
    input  logic [4:0]  m_rn,
    input  logic [31:0] m_alu,
    input  logic [31:0] m_mdata,
    input  logic        flush,
    output logic        stall,
    output logic        ewreg,
    output logic        em2reg,
    output logic        ewmem,
    output logic        ealuimm,
    output logic [3:0]  ealuc,
    output logic [4:0]  ern,
    output logic [31:0] ea,
    output logic [31:0] eb,
    output logic [31:0] eimm,
    output logic        evalid
);

    exe_t            e_reg;
    exe_t            e_next;
    logic            load_hazard;
    logic [1:0][4:0]  src_sel;
    logic [1:0][31:0] q_sel;
    logic [1:0][31:0] opnd;

    // Index 0 is the A operand (rs), index 1 the B operand (rt).
    assign src_sel = {d_rt, d_rs};
    assign q_sel   = {d_qb, d_qa};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            fwd_sel u_fwd_sel (
                .ewreg   (e_reg.wreg),
                .em2reg  (e_reg.m2reg),
                .ern     (e_reg.rn),
                .m_wreg  (m_wreg),
                .m_m2reg (m_m2reg),
                .m_rn    (m_rn),
                .src     (src_sel[gi]),
                .qreg    (q_sel[gi]),
                .e_alu   (e_alu),
                .m_alu   (m_alu),
                .m_mdata (m_mdata),
                .opnd    (opnd[gi])
            );
        end
    endgenerate

    assign load_hazard = e_reg.wreg && e_reg.m2reg && (e_reg.rn != REG_ZERO) &&
                         ((e_reg.rn == d_rs) || (d_uses_rt && (e_reg.rn == d_rt)));

    // A flush already squashes the consumer, so it suppresses the stall.
    assign stall = load_hazard && !flush;

    always_comb begin
        e_next = '0;
        if (!(load_hazard || flush)) begin
            e_next.wreg   = d_wreg;
            e_next.m2reg  = d_m2reg;
            e_next.wmem   = d_wmem;
            e_next.aluimm = d_aluimm;
            e_next.aluc   = d_aluc;
            e_next.rn     = d_rn;
            e_next.a      = opnd[0];
            e_next.b      = opnd[1];
            e_next.imm    = d_imm;
            e_next.valid  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            e_reg <= '0;
        end else begin
            e_reg <= e_next;
        end
    end

    assign ewreg   = e_reg.wreg;
    assign em2reg  = e_reg.m2reg;
    assign ewmem   = e_reg.wmem;
    assign ealuimm = e_reg.aluimm;
    assign ealuc   = e_reg.aluc;
    assign ern     = e_reg.rn;
    assign ea      = e_reg.a;
    assign eb      = e_reg.b;
    assign eimm    = e_reg.imm;
    assign evalid  = e_reg.valid;

endmodule

// File: doc/id_exe_pipe.md
ID_EXE_PIPE -- requirements
Module: id_exe_pipe

Interface
REQ-001 SHALL: clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL: rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL: d_wreg, d_m2reg, d_wmem, d_aluimm  in  1 each  decoded ID-stage control bits.
REQ-004 SHALL: d_aluc  in  4  decoded ALU op (0000 add, 0100 sub, 0001 and, 0101 or, 0010 xor).
REQ-005 SHALL: d_rs, d_rt  in  5 each  source register numbers; d_uses_rt  in  1  rt is read as a source.
REQ-006 SHALL: d_rn  in  5  destination register, already selected between rt and rd.
REQ-007 SHALL: d_qa, d_qb, d_imm  in  32 each  register-file outputs and sign-extended immediate.
REQ-008 SHALL: e_alu  in  32  current EXE ALU result; m_wreg, m_m2reg  in  1; m_rn  in  5; m_alu, m_mdata  in  32  MEM-stage state and data.
REQ-009 SHALL: flush  in  1  squash the ID instruction.
REQ-010 SHALL: stall  out  1  combinational load-use hazard; upstream PC and IF/ID hold while high.
REQ-011 SHALL: ewreg, em2reg, ewmem, ealuimm  out  1; ealuc  out  4; ern  out  5; ea, eb, eimm  out  32; evalid  out  1  registered EXE-stage outputs.

Function
REQ-012 SHALL: fwda = 01 if ewreg & em2reg==0 & ern!=0 & ern==d_rs; else 10 if m_wreg & !m_m2reg & m_rn!=0 & m_rn==d_rs; else 11 if m_wreg & m_m2reg & m_rn!=0 & m_rn==d_rs; else 00.
REQ-013 SHALL: fwdb uses the same rule against d_rt, whether or not d_uses_rt is set.
REQ-014 SHALL: the A operand select is 00 d_qa, 01 e_alu, 10 m_alu, 11 m_mdata; the B operand select is identical with d_qb.
REQ-015 SHALL: EXE match beats MEM match; register 0 is never forwarded.
REQ-016 SHALL: stall = ewreg & em2reg & ern!=0 & (ern==d_rs | (d_uses_rt & ern==d_rt)) & !flush.
REQ-017 SHALL: on each edge with stall or flush, load a bubble: all control outputs 0, ern 0, evalid 0, and ea/eb/eimm 0.
REQ-018 SHALL: otherwise, latch d_* control, d_rn, the forwarded A/B operands and d_imm, and set evalid=1.
REQ-019 SHALL: latency is exactly 1 cycle from ID inputs to E outputs; no internal buffering beyond one stage.
REQ-020 SHALL: stall lasts exactly one cycle per load-use pair, because the bubble clears em2reg.
REQ-021 SHALL: flush and stall together load one bubble, with stall output low.
REQ-022 SHALL: widths are exact and no arithmetic is performed; all comparisons are 5-bit equality.

Reset
REQ-023 SHALL: when rst=1 at an edge, all registered outputs go to 0 (evalid=0, ewreg=0, ewmem=0), regardless of stall/flush.
REQ-024 SHALL: stall is 0 in the cycle after reset, since em2reg=0.
REQ-025 SHALL: reset mid-stall discards the stalled pairing; the next non-reset edge loads the ID inputs normally.

Structure
REQ-026 SHALL: a shared package holds the ALU op codes (ALU_ADD..ALU_XOR), forwarding select codes (FWD_REG/FWD_EALU/FWD_MALU/FWD_MMEM), and the REG_ZERO constant.
REQ-027 SHALL: forwarding select and operand mux live in one sub-module, fwd_sel, instantiated twice (A and B); stall logic and the pipeline register live in id_exe_pipe.

Verification
REQ-028 SHALL: add r3,r1,r2 followed by sub r4,r3,r1 (ewreg=1, em2reg=0, ern=3, e_alu=0x0000_0010) -> fwda=01; next cycle ea=0x10.
REQ-029 SHALL: lw r5 followed by and r6,r5,r2 -> stall=1 for one cycle, bubble loaded (evalid=0, ewreg=0); next cycle stall=0, MEM forward 11, ea=m_mdata=0xDEAD_BEEF.
REQ-030 SHALL: ern=7 (ALU) and m_rn=7 (ALU), d_rs=7, e_alu=1, m_alu=2 -> ea=1 (EXE priority).
REQ-031 SHALL: d_rs=0 with ern=0, ewreg=1, e_alu=0xFFFF_FFFF, d_qa=0 -> ea=0 (no forward from r0).
REQ-032 SHALL: load-use hazard with flush=1 -> stall=0, bubble loaded; rst=1 with valid inputs -> all outputs 0 next cycle.
